// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: state encoding, widths, boot address.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = 32'h0;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   // One fetched instruction together with the word address it came from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_pair_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; power-of-two DEPTH, head read combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output logic [W-1:0]             pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr];

   // Pointer and occupancy update; flush empties the queue in one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset because occupancy gates the head.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues PC to imem, pairs returned word with its PC, queues pairs to decode.
// Latency: PC seen in cycle N is at the queue head in N+2; refill_flag is combinational.
// Backpressure: out_ready stalls the queue; a fetch that finds it full is dropped and replayed via refill.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int              DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      pc_addr,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INST_W-1:0]      imem_rdata,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_addr,
   output logic                   refill_flag,
   output logic [ADDR_W-1:0]      refill_addr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [INST_W-1:0]      out_inst,
   output logic [$clog2(DEPTH):0] count
);

   fetch_state_t      state;
   logic              s1_valid;
   logic [ADDR_W-1:0] s1_pc;
   logic [ADDR_W-1:0] replay_pc;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              pop_hs;
   logic              redirect_take;
   logic              overflow;
   fetch_pair_t       push_pair;
   fetch_pair_t       head_pair;

   // The PC runs freely, so the memory is always addressed by the live PC.
   assign imem_addr = pc_addr;

   // Redirects are ignored while booting; otherwise they win over everything.
   assign redirect_take = redirect_valid && (state != BOOT);
   assign pop_hs        = out_valid && out_ready;

   // A fetch that meets a full queue with no pop to make room is an overflow.
   assign overflow  = s1_valid && fifo_full && !pop_hs && !redirect_take;
   assign fifo_push = s1_valid && !redirect_take && (!fifo_full || pop_hs);
   assign fifo_pop  = pop_hs && !redirect_take;

   assign push_pair.pc   = s1_pc;
   assign push_pair.inst = imem_rdata;

   // Head is forced to zero while empty so decode never sees stale storage.
   assign out_valid = !fifo_empty;
   assign out_pc    = fifo_empty ? '0 : head_pair.pc;
   assign out_inst  = fifo_empty ? '0 : head_pair.inst;

   // PC load request: boot address, then redirect target, then replay of a dropped fetch.
   always_comb begin
      refill_flag = 1'b0;
      refill_addr = '0;
      if (state == BOOT) begin
         refill_flag = 1'b1;
         refill_addr = RESET_ADDR;
      end else if (redirect_valid) begin
         refill_flag = 1'b1;
         refill_addr = redirect_addr;
      end else if ((state == HOLD) && !fifo_full) begin
         refill_flag = 1'b1;
         refill_addr = replay_pc;
      end
   end

   // Fetch control: capture stage, overflow bookkeeping and state transitions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         s1_valid  <= 1'b0;
         s1_pc     <= '0;
         replay_pc <= '0;
      end else if (redirect_take) begin
         state    <= RUN;
         s1_valid <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state    <= RUN;
               s1_valid <= 1'b0;
            end
            RUN: begin
               if (overflow) begin
                  // The PC already moved past the dropped word; reload it later.
                  replay_pc <= s1_pc;
                  s1_valid  <= 1'b0;
                  state     <= HOLD;
               end else begin
                  s1_valid <= 1'b1;
                  s1_pc    <= pc_addr;
               end
            end
            HOLD: begin
               s1_valid <= 1'b0;
               if (!fifo_full) state <= RUN;
            end
            default: begin
               state    <= BOOT;
               s1_valid <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_pair_t))
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_dat (push_pair),
      .pop      (fifo_pop),
      .flush    (redirect_take),
      .pop_dat  (head_pair),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: free-running PC and synchronous imem models around the DUT.
// Order scoreboard checks every accepted instruction against the expected path.
// Directed tables and sequences cover boot, overflow/replay, redirect and reset.
module tb_fetch_queue;
   import cpu_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] K     = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        refill_flag;
   logic [31:0] refill_addr;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_addr        (pc_addr),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .refill_flag    (refill_flag),
      .refill_addr    (refill_addr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .count          (count)
   );

   always #5 clk = ~clk;

   // Program counter: loads on refill, otherwise advances one word per cycle.
   logic [31:0] pc_reg;
   assign pc_addr = pc_reg;
   always @(posedge clk) pc_reg <= refill_flag ? refill_addr : pc_reg + 32'd1;

   // Synchronous instruction memory with a recognisable content pattern.
   always @(posedge clk) imem_rdata <= imem_addr ^ K;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycles since reset release; cycle 0 is the boot cycle.
   int cyc;
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Reference model: the decode-visible stream is one contiguous path that
   // starts at the boot address and restarts at each honoured redirect target.
   logic [31:0] exp_pc;
   int          idle;
   always @(negedge clk) begin
      if (!rst) begin
         exp_pc = 32'h0;
         idle   = 0;
      end else begin
         chk("valid_vs_count", {31'd0, out_valid}, {31'd0, (count != 3'd0)});
         chk("count_bound", {31'd0, (count <= 3'(DEPTH))}, 32'd1);
         if (!refill_flag) chk("refill_addr_idle", refill_addr, 32'h0);
         if (redirect_valid && cyc != 0) begin
            exp_pc = redirect_addr;
            idle   = 0;
         end else if (out_valid && out_ready) begin
            chk("order_pc", out_pc, exp_pc);
            chk("order_inst", out_inst, exp_pc ^ K);
            exp_pc = exp_pc + 32'd1;
            idle   = 0;
         end else if (out_ready) begin
            idle++;
            if (idle == 16) begin
               chk("liveness", 32'd0, 32'd1);
               idle = 0;
            end
         end else begin
            idle = 0;
         end
      end
   end

   typedef struct {
      logic        rst_before;
      logic        rdy;
      logic        redir;
      logic [31:0] raddr;
      logic        rf;
      logic [31:0] ra;
      logic        ov;
      logic [31:0] opc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs [16];

   task automatic do_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int nref;

   initial begin
      // Boot with decode always ready; a redirect during boot must be ignored.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h0, 1'b0, 32'h0, 3'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h1, 3'd1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h2, 3'd1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h3, 3'd1};
      // Decode stalled from reset: queue fills with PCs 0..3 then holds.
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 1'b0, 32'h0, 3'd0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd2};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd3};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd4};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd4};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h0, 3'd4};

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rst_before) do_reset();
         out_ready      = vecs[i].rdy;
         redirect_valid = vecs[i].redir;
         redirect_addr  = vecs[i].raddr;
         @(negedge clk);
         chk($sformatf("vec%0d_refill_flag", i), {31'd0, refill_flag}, {31'd0, vecs[i].rf});
         chk($sformatf("vec%0d_refill_addr", i), refill_addr, vecs[i].ra);
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
         chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].opc);
         chk($sformatf("vec%0d_count", i), {29'd0, count}, {29'd0, vecs[i].cnt});
         step();
      end

      // Held after overflow: one pop releases exactly one replay of PC 4.
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_state", 32'(dut.state), 32'(HOLD));
      chk("hold_replay_pc", dut.replay_pc, 32'h4);
      chk("hold_no_refill_while_full", {31'd0, refill_flag}, 32'd0);
      chk("hold_head_pc", out_pc, 32'h0);
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("replay_flag", {31'd0, refill_flag}, 32'd1);
      chk("replay_addr", refill_addr, 32'h4);
      chk("replay_count", {29'd0, count}, 32'd3);
      step();
      @(negedge clk);
      chk("replay_once", {31'd0, refill_flag}, 32'd0);
      chk("replay_state_run", 32'(dut.state), 32'(RUN));
      chk("replay_head_pc", out_pc, 32'h1);
      step();
      out_ready = 1'b1;
      nref = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (refill_flag) nref++;
         step();
      end
      chk("replay_no_extra_refill", nref, 0);

      // Redirect while three entries are queued.
      do_reset();
      for (int i = 0; i < 5; i++) step();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h100;
      @(negedge clk);
      chk("redir_count_before", {29'd0, count}, 32'd3);
      chk("redir_flag", {31'd0, refill_flag}, 32'd1);
      chk("redir_addr", refill_addr, 32'h100);
      step();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      @(negedge clk);
      chk("redir_flushed", {29'd0, count}, 32'd0);
      chk("redir_flushed_valid", {31'd0, out_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("redir_r2_valid", {31'd0, out_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("redir_r3_valid", {31'd0, out_valid}, 32'd1);
      chk("redir_r3_pc", out_pc, 32'h100);
      step();
      for (int i = 0; i < 10; i++) step();

      // Redirect in the same cycle as an overflow: no replay afterwards.
      do_reset();
      for (int i = 0; i < 6; i++) step();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h200;
      @(negedge clk);
      chk("redov_count_full", {29'd0, count}, 32'd4);
      chk("redov_flag", {31'd0, refill_flag}, 32'd1);
      chk("redov_addr", refill_addr, 32'h200);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redov_state", 32'(dut.state), 32'(RUN));
      chk("redov_flushed", {29'd0, count}, 32'd0);
      nref = 0;
      for (int i = 0; i < 5; i++) begin
         if (refill_flag) nref++;
         step();
         @(negedge clk);
      end
      chk("redov_no_replay", nref, 0);
      chk("redov_head_pc", out_pc, 32'h200);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) step();

      // Full queue with simultaneous pop and push stays full without overflow.
      do_reset();
      for (int i = 0; i < 6; i++) step();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("fullpp%0d_count", i), {29'd0, count}, 32'd4);
         chk($sformatf("fullpp%0d_refill", i), {31'd0, refill_flag}, 32'd0);
         chk($sformatf("fullpp%0d_state", i), 32'(dut.state), 32'(RUN));
         step();
      end

      // Randomised traffic with a mid-stream asynchronous reset.
      for (int i = 0; i < 3000; i++) begin
         int mode;
         mode = (i / 64) % 4;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 0);
            2:       out_ready = ($urandom_range(0, 7) == 0);
            default: out_ready = ($urandom_range(0, 9) != 0);
         endcase
         redirect_valid = ($urandom_range(0, 39) == 0);
         redirect_addr  = $urandom & 32'h000F_FFF0;
         if (i == 1500) begin
            @(posedge clk);
            #3;
            rst            = 1'b0;
            redirect_valid = 1'b0;
            #1;
            chk("midrst_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_count", {29'd0, count}, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_boot_flag", {31'd0, refill_flag}, 32'd1);
            chk("midrst_boot_addr", refill_addr, 32'h0);
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
